game_progress_fsm: RTL and testbench
====================================

# game_progress_fsm

Game-progress controller for the maze game. It tracks world, level and lives from player outcome codes and a start button, and sequences the start, playing, transition and end-of-game phases. It sits directly upstream of the obstacle (world), scroll (level) and screen (game status) generators and drives their world/level/status selects. It replaces the hard-wired World/Level switches.

## Interface
- `NUM_WORLDS`, default 4: worlds per game; 1..8.
- `LEVELS_PER_WORLD`, default 4: levels per world; 1..8.
- `START_LIVES`, default 3: lives at reset and at new game; 1..MAX_LIVES.
- `MAX_LIVES`, default 9: saturation limit for bonus lives; ≤15.
- `SCREEN_HOLD`, default 50_000_000: cycles spent in each transition state; ≥1.

Ports:
- `clk` input 1: system clock (100 MHz).
- `rst` input 1: reset. Synchronous and active-high.
- `start_btn` input 1: start button. Already debounced and synchronous to `clk`.
- `player_status` input 2: player outcome. 0 = playing, 1 = level passed, 2 = died, 3 = ignored.
- `game_status` output 3: current state code (see Operation).
- `world` output 3: current world index, 0-based.
- `level` output 3: current level index within the world, 0-based.
- `lives` output 4: remaining lives.
- `round_start` output 1: one-cycle pulse on the first cycle of every PLAYING entry. Used to re-init the player and scroll objects.

## Operation

State codes on `game_status`:
- 0 START
- 1 PLAYING
- 2 LEVEL_INC
- 3 WORLD_INC
- 4 LIFE_LOST
- 5 LOSE
- 6 WIN
- Code 7 is unused. An illegal state recovers to START.

Start-button edge:
- `start_edge` = `start_btn` & ~`start_btn_q`.
- `start_btn_q` is a register; it resets to 1, so a button held through reset does not fire.

Arm flag:
- Cleared whenever the state is not PLAYING.
- Set in PLAYING on any cycle where `player_status` == 0.
- A status event is accepted only while armed. A stale 1/2 code left over from the previous round is therefore ignored until the code returns to 0.

Transitions (all on the clock edge):
- START
  - On `start_edge` -> PLAYING.
  - All other inputs are ignored.
- PLAYING, armed, `player_status` == 1:
  - If `level` < LEVELS_PER_WORLD-1 -> LEVEL_INC, with `level`+1.
  - Else if `world` < NUM_WORLDS-1 -> WORLD_INC, with `level`=0, `world`+1 and `lives`+1 (saturating at MAX_LIVES).
  - Else -> WIN. Counters are unchanged.
- PLAYING, armed, `player_status` == 2:
  - If `lives` > 1 -> LIFE_LOST, with `lives`-1. Level and world are unchanged.
  - Else -> LOSE, with `lives`=0.
- LEVEL_INC / WORLD_INC / LIFE_LOST:
  - The hold counter counts 0..SCREEN_HOLD-1.
  - At terminal count -> PLAYING and the counter clears.
  - `start_btn` and `player_status` are ignored.
- LOSE / WIN
  - On `start_edge` -> START, with `world`=0, `level`=0, `lives`=START_LIVES.
- `player_status` == 3 never causes a transition.

Counter updates:
- World, level and lives change only on the transition edge into the new state.
- All arithmetic stays in range by construction; no wrap-around is possible.

## Timing
Reset values (after the first rising edge with `rst`=1):
- `game_status`=0, `world`=0, `level`=0, `lives`=START_LIVES.
- `round_start`=0, arm=0, hold counter=0.

Event latency:
- A qualifying input sampled at edge k is visible on the outputs after edge k.
- There is one edge of latency; all outputs are registered with no combinational input-to-output paths.

Transition states:
- Each one lasts exactly SCREEN_HOLD cycles.
- Entry at edge k means PLAYING is entered at edge k+SCREEN_HOLD.

`round_start`:
- High for exactly the first cycle in PLAYING, covering entry from START and from every transition state.

Arming after PLAYING entry:
- The earliest possible accept is one cycle after the first `player_status`==0 sample.
- If `player_status`==0 at entry, arm is set at edge e+1 and an event can be accepted at edge e+2.

Reset mid-operation:
- `rst` dominates every input.
- It forces reset values on that edge, including during a hold, WIN or LOSE.

## Structure
Shared package `game_pkg` holds:
- the state code localparams (START..WIN);
- the player-status codes (PS_PLAYING=0, PS_PASS=1, PS_DIED=2);
- `HOLD_W` = $clog2(SCREEN_HOLD+1).

The obstacle, scroll and screen blocks import the same codes.

One sub-module, `hold_timer`:
- Ports: `clk`, `rst`, `clr`, `en`, and `done` (pulses at terminal count).
- Parameterised by SCREEN_HOLD.
- The state register, counters and arm flag stay in the top module.

## Test plan
Every scenario uses SCREEN_HOLD=4, NUM_WORLDS=2, LEVELS_PER_WORLD=2, START_LIVES=2 and MAX_LIVES=3.

1. **Reset and start with held button.** Hold `start_btn`=1 through reset, then keep it held for 5 cycles.
   - Status remains 0.
   - Release, then press: status=1 one edge later, with `round_start` high for 1 cycle.
2. **Level pass.** In PLAYING with status 0 then 1.
   - `level`=1 and status=2 for exactly 4 cycles, then status=1.
   - Holding status=1 across PLAYING re-entry causes no second event until status returns to 0.
3. **World pass.** Pass from world 0, level 1.
   - `world`=1, `level`=0, `lives`=3 and status=3.
   - A second world bonus at `lives`=3 stays at 3.
4. **Death and game over.** `lives`=2, died: `lives`=1 and status=4 for 4 cycles.
   - Died again: status=5 and `lives`=0.
   - Start edge: status=0, world=0, level=0, lives=2.
5. **Win.** Pass world 1, level 1: status=6 with counters held.
   - `player_status` changes are ignored.
   - A start edge returns to START.
6. **Robustness.** Assert `rst` in the 2nd cycle of LEVEL_INC: all reset values on the next edge.
   - `player_status`=3 held in PLAYING for 10 cycles causes no transition.

Source files
------------

// File: rtl/game_pkg.sv
// Shared codes for the maze game: game state encoding, player outcome codes
// and the hold-counter width helper used by the progress controller.
package game_pkg;

  localparam logic [2:0] START     = 3'd0;
  localparam logic [2:0] PLAYING   = 3'd1;
  localparam logic [2:0] LEVEL_INC = 3'd2;
  localparam logic [2:0] WORLD_INC = 3'd3;
  localparam logic [2:0] LIFE_LOST = 3'd4;
  localparam logic [2:0] LOSE      = 3'd5;
  localparam logic [2:0] WIN       = 3'd6;

  typedef enum logic [2:0] {
    S_START     = START,
    S_PLAYING   = PLAYING,
    S_LEVEL_INC = LEVEL_INC,
    S_WORLD_INC = WORLD_INC,
    S_LIFE_LOST = LIFE_LOST,
    S_LOSE      = LOSE,
    S_WIN       = WIN
  } game_state_t;

  localparam logic [1:0] PS_PLAYING = 2'd0;
  localparam logic [1:0] PS_PASS    = 2'd1;
  localparam logic [1:0] PS_DIED    = 2'd2;

  localparam int DEFAULT_SCREEN_HOLD = 50_000_000;

  // Enough bits to hold the value SCREEN_HOLD itself, so SCREEN_HOLD=1 still gets one bit.
  function automatic int hold_width(input int hold);
    return $clog2(hold + 1);
  endfunction

  localparam int HOLD_W = hold_width(DEFAULT_SCREEN_HOLD);

endpackage

// File: rtl/hold_timer.sv
// Counts 0..SCREEN_HOLD-1 while enabled and pulses done on the terminal count,
// clearing itself so back-to-back holds each last exactly SCREEN_HOLD cycles.
module hold_timer
  import game_pkg::*;
#(
  parameter int SCREEN_HOLD = DEFAULT_SCREEN_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CW = hold_width(SCREEN_HOLD);
  localparam logic [CW-1:0] LAST = CW'(SCREEN_HOLD - 1);

  logic [CW-1:0] count;

  assign done = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || done) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/game_progress_fsm.sv
// Game-progress controller: tracks world, level and lives from player outcome
// codes and the start button, and sequences start/play/transition/end phases.
module game_progress_fsm
  import game_pkg::*;
#(
  parameter int NUM_WORLDS       = 4,
  parameter int LEVELS_PER_WORLD = 4,
  parameter int START_LIVES      = 3,
  parameter int MAX_LIVES        = 9,
  parameter int SCREEN_HOLD      = DEFAULT_SCREEN_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [1:0] player_status,
  output logic [2:0] game_status,
  output logic [2:0] world,
  output logic [2:0] level,
  output logic [3:0] lives,
  output logic       round_start
);

  localparam logic [2:0] LAST_WORLD = 3'(NUM_WORLDS - 1);
  localparam logic [2:0] LAST_LEVEL = 3'(LEVELS_PER_WORLD - 1);
  localparam logic [3:0] INIT_LIVES = 4'(START_LIVES);
  localparam logic [3:0] LIVES_CAP  = 4'(MAX_LIVES);

  game_state_t state_q, state_d;
  logic [2:0]  world_q, world_d;
  logic [2:0]  level_q, level_d;
  logic [3:0]  lives_q, lives_d;
  logic        arm_q, arm_d;
  logic        start_btn_q;
  logic        round_start_q, round_start_d;
  logic        start_edge;
  logic        in_hold;
  logic        hold_done;

  // start_btn_q resets high so a button held through reset does not count as a press.
  assign start_edge = start_btn & ~start_btn_q;

  assign in_hold = (state_q == S_LEVEL_INC) || (state_q == S_WORLD_INC) ||
                   (state_q == S_LIFE_LOST);

  hold_timer #(
    .SCREEN_HOLD(SCREEN_HOLD)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .clr (~in_hold),
    .en  (in_hold),
    .done(hold_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_START;
      world_q       <= '0;
      level_q       <= '0;
      lives_q       <= INIT_LIVES;
      arm_q         <= 1'b0;
      start_btn_q   <= 1'b1;
      round_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      world_q       <= world_d;
      level_q       <= level_d;
      lives_q       <= lives_d;
      arm_q         <= arm_d;
      start_btn_q   <= start_btn;
      round_start_q <= round_start_d;
    end
  end

  // Arming requires a fresh PS_PLAYING sample, so stale pass/died codes from the
  // previous round cannot retrigger an event right after re-entering PLAYING.
  always_comb begin
    state_d = state_q;
    world_d = world_q;
    level_d = level_q;
    lives_d = lives_q;
    arm_d   = (state_q == S_PLAYING) && (arm_q || (player_status == PS_PLAYING));

    case (state_q)
      S_START: begin
        if (start_edge) begin
          state_d = S_PLAYING;
        end
      end
      S_PLAYING: begin
        if (arm_q && (player_status == PS_PASS)) begin
          if (level_q < LAST_LEVEL) begin
            state_d = S_LEVEL_INC;
            level_d = level_q + 3'd1;
          end else if (world_q < LAST_WORLD) begin
            state_d = S_WORLD_INC;
            level_d = '0;
            world_d = world_q + 3'd1;
            if (lives_q < LIVES_CAP) begin
              lives_d = lives_q + 4'd1;
            end
          end else begin
            state_d = S_WIN;
          end
        end else if (arm_q && (player_status == PS_DIED)) begin
          if (lives_q > 4'd1) begin
            state_d = S_LIFE_LOST;
            lives_d = lives_q - 4'd1;
          end else begin
            state_d = S_LOSE;
            lives_d = '0;
          end
        end
      end
      S_LEVEL_INC, S_WORLD_INC, S_LIFE_LOST: begin
        if (hold_done) begin
          state_d = S_PLAYING;
        end
      end
      S_LOSE, S_WIN: begin
        if (start_edge) begin
          state_d = S_START;
          world_d = '0;
          level_d = '0;
          lives_d = INIT_LIVES;
        end
      end
      default: begin
        state_d = S_START;
      end
    endcase

    round_start_d = (state_d == S_PLAYING) && (state_q != S_PLAYING);
  end

  assign game_status = state_q;
  assign world       = world_q;
  assign level       = level_q;
  assign lives       = lives_q;
  assign round_start = round_start_q;

endmodule

// File: tb/tb_game_progress_fsm.sv
// Directed, table-driven bench for game_progress_fsm with a short hold, plus a
// second instance starting at the lives cap to observe bonus-life saturation.
module tb_game_progress_fsm;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic [1:0] player_status;
  logic [2:0] game_status, world, level;
  logic [3:0] lives;
  logic       round_start;
  logic [2:0] sat_status, sat_world, sat_level;
  logic [3:0] sat_lives;
  logic       sat_round_start;

  game_progress_fsm #(
    .NUM_WORLDS(2), .LEVELS_PER_WORLD(2), .START_LIVES(2), .MAX_LIVES(3), .SCREEN_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .player_status(player_status),
    .game_status(game_status), .world(world), .level(level), .lives(lives),
    .round_start(round_start)
  );

  // Same stimulus, but it starts with lives already at the cap.
  game_progress_fsm #(
    .NUM_WORLDS(2), .LEVELS_PER_WORLD(2), .START_LIVES(3), .MAX_LIVES(3), .SCREEN_HOLD(HOLD)
  ) sat (
    .clk(clk), .rst(rst), .start_btn(start_btn), .player_status(player_status),
    .game_status(sat_status), .world(sat_world), .level(sat_level), .lives(sat_lives),
    .round_start(sat_round_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       btn;
    logic [1:0] ps;
    logic [2:0] st;
    logic [2:0] w;
    logic [2:0] l;
    logic [3:0] lv;
    logic       rs;
    logic       sat_chk;
    logic [3:0] sat_lv;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic addVec(input logic r, input logic b, input logic [1:0] ps,
                        input logic [2:0] st, input logic [2:0] w, input logic [2:0] l,
                        input logic [3:0] lv, input logic rs, input int n = 1);
    vec_t v;
    v.rst = r; v.btn = b; v.ps = ps; v.st = st; v.w = w; v.l = l; v.lv = lv; v.rs = rs;
    v.sat_chk = 1'b0; v.sat_lv = 4'd0;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic addSat(input logic [3:0] lv);
    vecs[vecs.size()-1].sat_chk = 1'b1;
    vecs[vecs.size()-1].sat_lv  = lv;
  endtask

  task automatic applyStimulus(input logic r, input logic b, input logic [1:0] ps);
    rst = r;
    start_btn = b;
    player_status = ps;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s at step %0d: got %0d, expected %0d", name, idx, actual, expected);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    start_btn = 1'b1;
    player_status = 2'd0;

    // Reset with the button held, then keep it held: no start.
    addVec(1,1,0, 0,0,0,2,0, 2); addSat(4'd3);
    addVec(0,1,0, 0,0,0,2,0, 5);
    addVec(0,0,0, 0,0,0,2,0);
    addVec(0,1,0, 1,0,0,2,1);
    addVec(0,0,0, 1,0,0,2,0);
    // Level pass; held pass code across re-entry is ignored until a 0 arrives.
    addVec(0,0,1, 2,0,1,2,0);
    addVec(0,0,1, 2,0,1,2,0, 3);
    addVec(0,0,1, 1,0,1,2,1);
    addVec(0,0,1, 1,0,1,2,0, 2);
    addVec(0,0,0, 1,0,1,2,0);
    // World pass with bonus life; the capped instance stays at 3.
    addVec(0,0,1, 3,1,0,3,0); addSat(4'd3);
    addVec(0,0,0, 3,1,0,3,0, 3);
    addVec(0,0,0, 1,1,0,3,1);
    addVec(0,0,0, 1,1,0,3,0);
    // Deaths down to game over, then restart.
    addVec(0,0,2, 4,1,0,2,0);
    addVec(0,0,2, 4,1,0,2,0, 3);
    addVec(0,0,2, 1,1,0,2,1);
    addVec(0,0,2, 1,1,0,2,0);
    addVec(0,0,0, 1,1,0,2,0);
    addVec(0,0,2, 4,1,0,1,0);
    addVec(0,0,0, 4,1,0,1,0, 3);
    addVec(0,0,0, 1,1,0,1,1);
    addVec(0,0,0, 1,1,0,1,0);
    addVec(0,0,2, 5,1,0,0,0);
    addVec(0,0,0, 5,1,0,0,0);
    addVec(0,1,0, 0,0,0,2,0);
    addVec(0,0,0, 0,0,0,2,0);
    addVec(0,1,0, 1,0,0,2,1);
    // Play through to WIN, then status codes are ignored until a start edge.
    addVec(0,0,0, 1,0,0,2,0);
    addVec(0,0,1, 2,0,1,2,0);
    addVec(0,0,0, 2,0,1,2,0, 3);
    addVec(0,0,0, 1,0,1,2,1);
    addVec(0,0,0, 1,0,1,2,0);
    addVec(0,0,1, 3,1,0,3,0);
    addVec(0,0,0, 3,1,0,3,0, 3);
    addVec(0,0,0, 1,1,0,3,1);
    addVec(0,0,0, 1,1,0,3,0);
    addVec(0,0,1, 2,1,1,3,0);
    addVec(0,0,0, 2,1,1,3,0, 3);
    addVec(0,0,0, 1,1,1,3,1);
    addVec(0,0,0, 1,1,1,3,0);
    addVec(0,0,1, 6,1,1,3,0);
    addVec(0,0,2, 6,1,1,3,0);
    addVec(0,0,0, 6,1,1,3,0);
    addVec(0,0,1, 6,1,1,3,0);
    addVec(0,1,0, 0,0,0,2,0);
    // Reset in the 2nd LEVEL_INC cycle, then status 3 held for 10 cycles.
    addVec(0,0,0, 0,0,0,2,0);
    addVec(0,1,0, 1,0,0,2,1);
    addVec(0,0,0, 1,0,0,2,0);
    addVec(0,0,1, 2,0,1,2,0);
    addVec(0,1,0, 2,0,1,2,0);
    addVec(1,1,0, 0,0,0,2,0);
    addVec(0,1,0, 0,0,0,2,0);
    addVec(0,0,0, 0,0,0,2,0);
    addVec(0,1,0, 1,0,0,2,1);
    addVec(0,0,0, 1,0,0,2,0);
    addVec(0,0,3, 1,0,0,2,0, 10);
    addVec(0,0,0, 1,0,0,2,0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].btn, vecs[i].ps);
      checkOutput("game_status", i, int'(game_status), int'(vecs[i].st));
      checkOutput("world", i, int'(world), int'(vecs[i].w));
      checkOutput("level", i, int'(level), int'(vecs[i].l));
      checkOutput("lives", i, int'(lives), int'(vecs[i].lv));
      checkOutput("round_start", i, int'(round_start), int'(vecs[i].rs));
      if (vecs[i].sat_chk) begin
        checkOutput("sat_lives", i, int'(sat_lives), int'(vecs[i].sat_lv));
      end
    end

    // Hold length measured on a LIFE_LOST after the earlier mid-hold reset.
    applyStimulus(1'b0, 1'b0, 2'd2);
    checkOutput("life_lost_entry", 1000, int'(game_status), 4);
    checkOutput("life_lost_lives", 1000, int'(lives), 1);
    cnt = 1;
    while (game_status == 3'd4 && cnt < 20) begin
      applyStimulus(1'b0, 1'b0, 2'd0);
      if (game_status == 3'd4) cnt++;
    end
    checkOutput("hold_cycles", 1001, cnt, HOLD);
    checkOutput("hold_exit_status", 1001, int'(game_status), 1);
    checkOutput("hold_exit_round_start", 1001, int'(round_start), 1);
    applyStimulus(1'b0, 1'b0, 2'd0);
    checkOutput("round_start_single", 1002, int'(round_start), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
